// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: ALUop decode and sequencing for an external bit-sliced ALU
// Decodes an R-type funct into the 4-bit ALUop, drives the ALU for one cycle and
// returns its result over valid/ready. SLL/SRL are done here because the ALU
// slices return a constant for them.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o     request handshake (funct_i, shamt_i, op_a_i, op_b_i)
//   alu_op_o, alu_a_o, alu_b_o  ALUop and operands to the ALU slices
//   alu_result_i                combinational ALU result
//   out_valid_o / out_ready_i   result handshake (result_o, illegal_o)
// Build option: define ALU_CTRL_FAST_SHIFT_EN for a single-cycle barrel shift in EXEC.
module alu_ctrl_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [5:0]       funct_i,
    input  logic [4:0]       shamt_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [3:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;
    state_e state_q, state_d;
    logic [3:0] op_q, op_d, dec_op;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [4:0] cnt_q, cnt_d;
    logic ill_q, ill_d, dec_ill, dec_shift, sh_q;
    assign sh_q = op_q[3:1] == 3'b100;
    always_comb begin
        dec_op  = 4'b0000;
        dec_ill = 1'b0;
        case (funct_i)
            6'h24: dec_op = 4'b0000;
            6'h25: dec_op = 4'b0001;
            6'h20: dec_op = 4'b0010;
            6'h27: dec_op = 4'b0101;
            6'h22: dec_op = 4'b0110;
            6'h2A: dec_op = 4'b0111;
            6'h00: dec_op = 4'b1000;
            6'h02: dec_op = 4'b1001;
            6'h21: dec_op = 4'b1010;
            6'h23: dec_op = 4'b1110;
            6'h2B: dec_op = 4'b1111;
            default: dec_ill = 1'b1;
        endcase
    end
    assign dec_shift = !dec_ill && dec_op[3:1] == 3'b100;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end
    // res_q doubles as the shift working register; for shamt==0 it already holds op_b.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                op_d  = dec_op;
                a_d   = op_a_i;
                b_d   = op_b_i;
                cnt_d = shamt_i;
                ill_d = dec_ill;
                res_d = dec_shift ? op_b_i : '0;
`ifdef ALU_CTRL_FAST_SHIFT_EN
                state_d = dec_ill || (dec_shift && shamt_i == 5'd0) ? DONE : EXEC;
`else
                state_d = dec_ill || (dec_shift && shamt_i == 5'd0) ? DONE : dec_shift ? SHIFT : EXEC;
`endif
            end
            EXEC: begin
`ifdef ALU_CTRL_FAST_SHIFT_EN
                res_d = !sh_q ? alu_result_i : op_q[0] ? b_q >> cnt_q : b_q << cnt_q;
`else
                res_d = alu_result_i;
`endif
                state_d = DONE;
            end
`ifndef ALU_CTRL_FAST_SHIFT_EN
            SHIFT: begin
                res_d   = op_q[0] ? res_q >> 1 : res_q << 1;
                cnt_d   = cnt_q - 5'd1;
                state_d = cnt_q == 5'd1 ? DONE : SHIFT;
            end
`endif
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready_o  = state_q == IDLE;
        out_valid_o = state_q == DONE;
        alu_op_o    = op_q;
        alu_a_o     = a_q;
        alu_b_o     = b_q;
        result_o    = res_q;
        illegal_o   = ill_q;
    end
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb_alu_ctrl_sequencer: scoreboard bench for alu_ctrl_sequencer with a behavioural ALU
module tb_alu_ctrl_sequencer;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic [31:0] op_a, op_b, alu_a, alu_b, alu_result, result;
    logic [3:0] alu_op;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_ctrl_sequencer #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .funct_i(funct), .shamt_i(shamt), .op_a_i(op_a), .op_b_i(op_b),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result), .illegal_o(illegal)
    );

    // External ALU slices; shift codes return a constant.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010, 4'b1010: alu_result = alu_a + alu_b;
            4'b0101: alu_result = ~(alu_a | alu_b);
            4'b0110, 4'b1110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1111: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'h5A5A_5A5A;
        endcase
    end

    task automatic drive(input logic [5:0] f, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        funct = f;
        shamt = s;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [5:0] f, input logic [4:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic ei, input int el, input logic chk_op, input logic [3:0] eop);
        exp_t e;
        int n;
        e.res = er;
        e.ill = ei;
        e.lat = el;
        sb.push_back(e);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before issue: got %b want 1", nm, in_ready);
        end
        drive(f, s, a, b);
        n = 1;
        if (chk_op) begin
            checks++;
            if (alu_op !== eop || alu_a !== a || alu_b !== b) begin
                errors++;
                $display("FAIL %s exec drive: got op=%b a=%h b=%h want op=%b a=%h b=%h",
                         nm, alu_op, alu_a, alu_b, eop, a, b);
            end
        end
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (out_valid=%b) want %0d", nm, n, out_valid, e.lat);
        end
        checks++;
        if (result !== e.res || illegal !== e.ill) begin
            errors++;
            $display("FAIL %s result: got %h ill=%b want %h ill=%b", nm, result, illegal, e.res, e.ill);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
        end
    endtask

    task automatic check_idle_reset(input string nm);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got rdy=%b vld=%b res=%h ill=%b want 1 0 0 0",
                     nm, in_ready, out_valid, result, illegal);
        end
        checks++;
        if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("FAIL %s alu drive: got op=%b a=%h b=%h want 0", nm, alu_op, alu_a, alu_b);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_reset("reset");
    endtask

    task automatic test_reset_mid_shift;
        drive(6'h00, 5'd20, 32'd0, 32'h0000_0003);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift busy: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_idle_reset("mid_shift_reset");
    endtask

    task automatic test_alu_ops;
        issue("add", 6'h20, 5'd0, 32'd5, 32'd7, 32'd12, 1'b0, 2, 1'b1, 4'b0010);
        issue("subu", 6'h23, 5'd0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2, 1'b1, 4'b1110);
        issue("sltu", 6'h2B, 5'd0, 32'd3, 32'd5, 32'd1, 1'b0, 2, 1'b1, 4'b1111);
        issue("slt", 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 2, 1'b1, 4'b0111);
        issue("nor", 6'h27, 5'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 2, 1'b1, 4'b0101);
        issue("and", 6'h24, 5'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 2, 1'b1, 4'b0000);
    endtask

    task automatic test_shifts;
        issue("sll31", 6'h00, 5'd31, 32'd0, 32'h0000_0001, 32'h8000_0000, 1'b0, 32, 1'b0, 4'b0000);
        issue("srl4", 6'h02, 5'd4, 32'd0, 32'h8000_0000, 32'h0800_0000, 1'b0, 5, 1'b0, 4'b0000);
        issue("sll1", 6'h00, 5'd1, 32'd0, 32'hC000_0001, 32'h8000_0002, 1'b0, 2, 1'b0, 4'b0000);
    endtask

    task automatic test_boundaries;
        issue("srl0", 6'h02, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 4'b0000);
        issue("illegal", 6'h26, 5'd3, 32'd9, 32'd9, 32'd0, 1'b1, 1, 1'b0, 4'b0000);
        issue("legal_after_ill", 6'h25, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 2, 1'b1, 4'b0001);
    endtask

    task automatic test_backpressure;
        int n;
        out_ready = 1'b0;
        drive(6'h20, 5'd0, 32'd5, 32'd7);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 10; i++) begin
            funct = 6'h3F;
            in_valid = i[0];
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd12 || illegal !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got vld=%b res=%h ill=%b rdy=%b want 1 0000000c 0 0",
                         i, out_valid, result, illegal, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure ignored_req: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        funct = 6'h0;
        shamt = 5'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        test_reset;
        test_reset_mid_shift;
        test_alu_ops;
        test_shifts;
        test_boundaries;
        test_backpressure;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
Drives the ALUop side of the bit-sliced ALU. It accepts an R-type funct/shamt request with two operands, decodes funct into the 4-bit ALUop code, and presents operands and ALUop to the external WIDTH-bit ripple ALU. It captures the ALU result and returns it over a valid/ready handshake. The ALU slices output a constant for SLL/SRL, so this block performs those shifts itself, iteratively, one bit per cycle.

Parameters:
WIDTH, 32, operand/result width; must equal the external ALU width.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
funct  input  6  MIPS R-type funct field
shamt  input  5  shift amount
op_a  input  WIDTH  rs operand
op_b  input  WIDTH  rt operand
alu_op  output  4  ALUop to the ALU slices
alu_a  output  WIDTH  ALU A operand
alu_b  output  WIDTH  ALU B operand
alu_result  input  WIDTH  combinational result from the ALU
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  final result
illegal  output  1  funct not supported; qualified by out_valid

Behaviour:
- ALUop decode (funct -> alu_op):
  - 0x24 AND -> 0000
  - 0x25 OR -> 0001
  - 0x20 ADD -> 0010
  - 0x27 NOR -> 0101
  - 0x22 SUB -> 0110
  - 0x2A SLT -> 0111
  - 0x00 SLL -> 1000
  - 0x02 SRL -> 1001
  - 0x21 ADDU -> 1010
  - 0x23 SUBU -> 1110
  - 0x2B SLTU -> 1111
  - Any other funct is illegal.
- States: IDLE, EXEC, SHIFT, DONE.
- Reset (synchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, illegal=0.
  - result, alu_a, alu_b all zero; alu_op=0000.
  - Reset overrides any in-flight operation; the partial result is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid, latch funct, shamt, op_a, op_b and the decoded op.
  - Next state:
    - Legal non-shift -> EXEC.
    - SLL/SRL with shamt!=0 -> SHIFT.
    - SLL/SRL with shamt==0 -> DONE, result=op_b.
    - Illegal funct -> DONE, result=0, illegal=1.
- EXEC (exactly 1 cycle):
  - Drive alu_op and alu_a/alu_b from the latched values.
  - At the end of the cycle, capture alu_result into result, then go to DONE.
- alu_op/alu_a/alu_b hold their latched values outside EXEC; they are don't-care to the ALU then.
- SHIFT:
  - Working register initialised to op_b; shift counter initialised to shamt.
  - Each cycle: shift by 1 (SLL: left, zero fill; SRL: logical right, zero fill) and decrement the counter.
  - When the counter reaches 1 on the active edge, go to DONE with the final value in result.
  - Takes exactly shamt cycles.
- DONE:
  - out_valid=1; result and illegal held stable while out_valid=1 && out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- in_ready=1 only in IDLE. No new request is accepted in the same cycle as the DONE handshake (no back-to-back overlap).
- Latency from the accept edge to out_valid:
  - Non-shift: 2 cycles.
  - Shift: shamt+1 cycles.
  - Illegal or shamt=0: 1 cycle.
- Arithmetic: ADD/SUB overflow is not reported; the result wraps modulo 2^WIDTH.
- Shift amounts >= WIDTH cannot occur (shamt max 31, WIDTH>=32). If WIDTH<32, the result becomes 0 once all bits are shifted out.
- in_valid while busy: ignored, because in_ready=0.

Optional Feature:
ALU_CTRL_FAST_SHIFT_EN
- Defined: SLL/SRL use a single-cycle barrel shift in EXEC. Shift latency becomes 2 cycles for any shamt (1 cycle when shamt==0); the SHIFT state is not synthesized.
- Undefined: the iterative SHIFT behaviour above applies.
- Results are identical in both builds.

Test Plan:
- Reset mid-SHIFT (SLL, shamt=20, reset asserted at cycle 5) -> next cycle in IDLE, in_ready=1, out_valid=0, result=0.
- ADD: funct=0x20, op_a=5, op_b=7, ALU model returns 12 -> alu_op=0010 during EXEC; out_valid 2 cycles after accept with result=12, illegal=0.
- SUBU then SLTU: funct=0x23 with op_a=3, op_b=5 -> alu_op=1110, result=0xFFFFFFFE. Then funct=0x2B with the same operands -> alu_op=1111, result=1.
- SLL: funct=0x00, op_b=0x0000_0001, shamt=31 -> out_valid 32 cycles after accept, result=0x8000_0000. SRL: op_b=0x8000_0000, shamt=4 -> result=0x0800_0000 after 5 cycles.
- Boundaries:
  - SRL with shamt=0 and op_b=0xDEAD_BEEF -> result=0xDEAD_BEEF after 1 cycle.
  - Illegal funct=0x26 -> illegal=1, result=0 after 1 cycle.
- Backpressure: out_ready held low 10 cycles in DONE -> out_valid, result and illegal stable; in_ready=0; in_valid pulses are ignored. Raising out_ready returns the block to IDLE with in_ready=1 the next cycle.
